vga_text_writer: RTL

//  Producer side of the character-buffer write port (char/addr/write-enable) of the VGA text display.

---
 rtl/vga_text_writer_pkg.sv | 24 ++
 rtl/vga_text_writer_if.sv | 33 +++
 rtl/vga_text_writer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/vga_text_writer_pkg.sv
// Shared constants for the VGA text writer: ASCII control codes,
// printable-range bounds and the controller state encoding.
package vga_text_pkg;

    // ASCII codes the writer reacts to
    localparam logic [7:0] CH_SPACE    = 8'h20;
    localparam logic [7:0] CH_CR       = 8'h0D;
    localparam logic [7:0] CH_LF       = 8'h0A;
    localparam logic [7:0] CH_BS       = 8'h08;
    localparam logic [7:0] CH_FF       = 8'h0C;
    localparam logic [7:0] CH_PRINT_LO = 8'h20;
    localparam logic [7:0] CH_PRINT_HI = 8'h7E;

    // Controller states; IDLE is the only state that accepts host bytes
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_CLR_LINE = 2'd1;
    localparam logic [1:0] ST_CLR_ALL  = 2'd2;

    // True for bytes that become a visible glyph in the character buffer
    function automatic logic is_printable(input logic [7:0] c);
        return (c >= CH_PRINT_LO) && (c <= CH_PRINT_HI);
    endfunction

endpackage

// File: rtl/vga_text_writer_if.sv
// Host byte stream (valid/ready) plus the character-buffer write port and
// cursor/status outputs of the VGA text writer.
interface vga_text_writer_if #(
    parameter int COLS   = 160,
    parameter int ROWS   = 128,
    parameter int ADDR_W = $clog2(COLS * ROWS),
    parameter int COL_W  = $clog2(COLS),
    parameter int ROW_W  = $clog2(ROWS)
) ();

    logic [7:0]        in_char;
    logic              in_valid;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [COL_W-1:0]  cursor_col;
    logic [ROW_W-1:0]  cursor_row;
    logic              busy;

    // Host / observer side: drives bytes, watches the buffer port
    modport master (
        output in_char, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data, cursor_col, cursor_row, busy
    );

    // Writer side: consumes bytes, drives the buffer port
    modport slave (
        input  in_char, in_valid,
        output in_ready, wr_en, wr_addr, wr_data, cursor_col, cursor_row, busy
    );

endinterface

// File: rtl/vga_text_writer.sv
// VGA text writer: turns a stream of ASCII bytes into single-cycle writes to
// the character buffer, tracking a cursor, handling CR/LF/BS, wrapping lines
// with clear-ahead of the new line, and running full-screen clears on FF or
// after reset. Row start addresses are kept incrementally; no multiplier.
module vga_text_writer
    import vga_text_pkg::*;
#(
    parameter int COLS           = 160,
    parameter int ROWS           = 128,
    parameter int ADDR_W         = $clog2(COLS * ROWS),
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic               clk,
    input  logic               reset,
    vga_text_writer_if.slave   bus
);

    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] LINE_LAST = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(COLS);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);

    // Where the controller lands when reset is applied
    localparam logic [1:0] ST_RESET = (CLEAR_ON_RESET != 0) ? ST_CLR_ALL : ST_IDLE;

    logic [1:0]        state_q,    state_d;
    logic [COL_W-1:0]  col_q,      col_d;
    logic [ROW_W-1:0]  row_q,      row_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] cnt_q,      cnt_d;
    logic              wr_en_q,    wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;
    logic [7:0]        wr_data_q,  wr_data_d;

    logic              accept;
    logic [ADDR_W-1:0] cell_addr;
    logic [ROW_W-1:0]  row_adv;
    logic [ADDR_W-1:0] base_adv;

    // Handshake: only IDLE takes bytes, and never while reset is held
    assign bus.in_ready = (state_q == ST_IDLE) && !reset;
    assign accept       = bus.in_valid && bus.in_ready;

    // Address of the cell under the cursor
    assign cell_addr = row_base_q + ADDR_W'(col_q);

    // Next row and its start address, wrapping from the last row to the top
    always_comb begin
        if (row_q == ROW_LAST) begin
            row_adv  = '0;
            base_adv = '0;
        end else begin
            row_adv  = row_q + 1'b1;
            base_adv = row_base_q + ROW_STEP;
        end
    end

    // Next-state logic: byte decode in IDLE, address sweeps in the clear states
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned, which would infer a latch.
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        cnt_d      = cnt_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_printable(bus.in_char)) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = cell_addr;
                        wr_data_d = bus.in_char;
                        if (col_q != COL_LAST) begin
                            col_d = col_q + 1'b1;
                        end else begin
                            // Glyph in the last column wraps and clears the new line
                            col_d      = '0;
                            row_d      = row_adv;
                            row_base_d = base_adv;
                            state_d    = ST_CLR_LINE;
                        end
                    end else begin
                        case (bus.in_char)
                            CH_CR: col_d = '0;
                            CH_LF: begin
                                col_d      = '0;
                                row_d      = row_adv;
                                row_base_d = base_adv;
                                state_d    = ST_CLR_LINE;
                            end
                            CH_BS: begin
                                // Backspace erases the previous cell; no wrap to the row above
                                if (col_q != '0) begin
                                    col_d     = col_q - 1'b1;
                                    wr_en_d   = 1'b1;
                                    wr_addr_d = cell_addr - ADDR_W'(1);
                                    wr_data_d = CH_SPACE;
                                end
                            end
                            CH_FF:   state_d = ST_CLR_ALL;
                            default: ;
                        endcase
                    end
                end
            end

            ST_CLR_LINE: begin
                wr_en_d   = 1'b1;
                wr_addr_d = row_base_q + cnt_q;
                wr_data_d = CH_SPACE;
                if (cnt_q == LINE_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_CLR_ALL: begin
                wr_en_d   = 1'b1;
                wr_addr_d = cnt_q;
                wr_data_d = CH_SPACE;
                if (cnt_q == LAST_ADDR) begin
                    // Screen is blank: home the cursor
                    cnt_d      = '0;
                    col_d      = '0;
                    row_d      = '0;
                    row_base_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State, cursor and registered write-port outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RESET;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            cnt_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values together.
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            cnt_q      <= cnt_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.cursor_col = col_q;
    assign bus.cursor_row = row_q;
    assign bus.busy       = (state_q != ST_IDLE);

endmodule
